// File: rtl/brisc_pkg.sv
// Shared widths for the brisc memory subsystem.
package brisc_pkg;
  parameter int ADDRESS_WIDTH    = 32;
  parameter int CACHE_LINE_WIDTH = 128;
endpackage

// File: rtl/main_mem_ctrl.sv
// Fixed-latency main memory model: one line request at a time, a one-cycle response pulse,
// and a HOLD state that waits for the arbiter to release mem_req before taking new work.
module main_mem_ctrl
  import brisc_pkg::*;
#(
  parameter int MEM_LATENCY     = 5,
  parameter int MEM_DEPTH_LINES = 256
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        mem_req,
  input  logic                        mem_write,
  input  logic [ADDRESS_WIDTH-1:0]    mem_addr,
  input  logic [CACHE_LINE_WIDTH-1:0] mem_data,
  output logic                        mem_busy,
  output logic                        mem_resp_valid,
  output logic [CACHE_LINE_WIDTH-1:0] mem_resp_data,
  output logic [1:0]                  dbg_state
);

  localparam int OFF = $clog2(CACHE_LINE_WIDTH / 8);
  localparam int IW  = $clog2(MEM_DEPTH_LINES);
  localparam int CW  = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);

  // Handshake: mem_req is held by the arbiter until it sees mem_resp_valid; the request is
  // taken on the first edge in IDLE with mem_req=1 and mem_req must fall before the next one.
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2, HOLD = 2'd3} state_t;

  state_t                      state, state_nx;
  logic [CW-1:0]               cnt;
  logic [IW-1:0]               idx_q;
  logic                        wr_q;
  logic [CACHE_LINE_WIDTH-1:0] data_q;
  logic [CACHE_LINE_WIDTH-1:0] mem [MEM_DEPTH_LINES];
  logic                        accept;
  logic                        resp_entry;
  logic                        unused_addr_bits;

  assign accept     = (state == IDLE) && mem_req;
  assign resp_entry = (state == BUSY) && (cnt == '0);

  // Only the line index is decoded; upper bits alias and the byte offset is ignored.
  assign unused_addr_bits = ^{mem_addr[ADDRESS_WIDTH-1:OFF+IW], mem_addr[OFF-1:0]};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (mem_req) state_nx = BUSY;
      BUSY:    if (cnt == '0) state_nx = RESP;
      RESP:    state_nx = mem_req ? HOLD : IDLE;
      HOLD:    if (!mem_req) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      mem_resp_data <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt <= CNT_LOAD;
      end else if ((state == BUSY) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (resp_entry && !wr_q) begin
        mem_resp_data <= mem[idx_q];
      end
    end
  end

  // Request capture; its contents only matter while the FSM is out of IDLE.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q  <= mem_addr[OFF +: IW];
      wr_q   <= mem_write;
      data_q <= mem_data;
    end
  end

  // Line storage survives reset; an aborted request never reaches resp_entry.
  always_ff @(posedge clk) begin
    if (resp_entry && wr_q) begin
      mem[idx_q] <= data_q;
    end
  end

  assign mem_busy       = (state != IDLE);
  assign mem_resp_valid = (state == RESP);
  assign dbg_state      = state;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Directed bench for main_mem_ctrl: latency 5 instance for the main scenarios and a
// latency 1 instance for back-to-back traffic.
module tb_main_mem_ctrl;
  import brisc_pkg::*;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [127:0] D1  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] D11 = {16{8'h11}};
  localparam logic [127:0] DFF = {16{8'hFF}};
  localparam logic [127:0] D2  = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;

  logic                        clk;
  logic                        reset_n;

  logic                        mem_req, mem_write;
  logic [ADDRESS_WIDTH-1:0]    mem_addr;
  logic [CACHE_LINE_WIDTH-1:0] mem_data;
  logic                        mem_busy, mem_resp_valid;
  logic [CACHE_LINE_WIDTH-1:0] mem_resp_data;
  logic [1:0]                  dbg_state;

  logic                        mem_req1, mem_write1;
  logic [ADDRESS_WIDTH-1:0]    mem_addr1;
  logic [CACHE_LINE_WIDTH-1:0] mem_data1;
  logic                        mem_busy1, mem_resp_valid1;
  logic [CACHE_LINE_WIDTH-1:0] mem_resp_data1;
  logic [1:0]                  dbg_state1;

  int vectors     = 0;
  int miscompares = 0;
  logic [127:0] exp_q[$];

  main_mem_ctrl #(.MEM_LATENCY(5), .MEM_DEPTH_LINES(256)) dut (
    .clk(clk), .reset_n(reset_n), .mem_req(mem_req), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_busy(mem_busy),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .dbg_state(dbg_state)
  );

  main_mem_ctrl #(.MEM_LATENCY(1), .MEM_DEPTH_LINES(256)) dut1 (
    .clk(clk), .reset_n(reset_n), .mem_req(mem_req1), .mem_write(mem_write1),
    .mem_addr(mem_addr1), .mem_data(mem_data1), .mem_busy(mem_busy1),
    .mem_resp_valid(mem_resp_valid1), .mem_resp_data(mem_resp_data1), .dbg_state(dbg_state1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Latency-5 transaction: accept, quiet for four cycles, pulse at k+5, drop req, back to IDLE.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [127:0] data,
                         input logic [127:0] rd_exp);
    logic [127:0] e;
    mem_req = 1'b1; mem_write = wr; mem_addr = addr; mem_data = data;
    if (!wr) exp_q.push_back(rd_exp);
    step(1);
    check("accept_busy", 128'(mem_busy), 128'(1));
    check("accept_no_valid", 128'(mem_resp_valid), 128'(0));
    mem_write = ~wr; mem_addr = addr ^ 32'h30; mem_data = ~data;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      check("latency_quiet", 128'(mem_resp_valid), 128'(0));
    end
    step(1);
    check("resp_valid_k5", 128'(mem_resp_valid), 128'(1));
    check("resp_state", 128'(dbg_state), 128'(S_RESP));
    if (!wr) begin
      e = exp_q.pop_front();
      check("rd_data", mem_resp_data, e);
    end
    mem_req = 1'b0;
    step(1);
    check("back_idle_busy", 128'(mem_busy), 128'(0));
    check("back_idle_valid", 128'(mem_resp_valid), 128'(0));
  endtask

  // Latency-1 transaction: accept at k, pulse at k+1, IDLE at k+2, next accept possible at k+3.
  task automatic run_txn1(input logic wr, input logic [31:0] addr, input logic [127:0] data,
                          input logic [127:0] rd_exp);
    logic [127:0] e;
    mem_req1 = 1'b1; mem_write1 = wr; mem_addr1 = addr; mem_data1 = data;
    if (!wr) exp_q.push_back(rd_exp);
    step(1);
    check("l1_accept_busy", 128'(mem_busy1), 128'(1));
    check("l1_accept_no_valid", 128'(mem_resp_valid1), 128'(0));
    step(1);
    check("l1_resp_k1", 128'(mem_resp_valid1), 128'(1));
    if (!wr) begin
      e = exp_q.pop_front();
      check("l1_rd_data", mem_resp_data1, e);
    end
    mem_req1 = 1'b0;
    step(1);
    check("l1_idle_busy", 128'(mem_busy1), 128'(0));
  endtask

  initial begin
    int pulses;
    int busy_low;
    logic [127:0] held_data;

    reset_n = 1'b0;
    mem_req = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_data = '0;
    mem_req1 = 1'b0; mem_write1 = 1'b0; mem_addr1 = '0; mem_data1 = '0;
    step(2);
    check("rst_state", 128'(dbg_state), 128'(S_IDLE));
    check("rst_busy", 128'(mem_busy), 128'(0));
    check("rst_valid", 128'(mem_resp_valid), 128'(0));
    check("rst_data", mem_resp_data, 128'(0));
    check("rst_busy_l1", 128'(mem_busy1), 128'(0));
    reset_n = 1'b1;
    step(1);

    // Seed 0x80, then write/read 0x40 with stale inputs scrambled after acceptance.
    run_txn(1'b1, 32'h80, D11, '0);
    run_txn(1'b1, 32'h40, D1, '0);
    run_txn(1'b0, 32'h40, '0, D1);
    check("rd_data_held_idle", mem_resp_data, D1);

    // Aliasing: 256 lines of 16 bytes wrap at 0x1000.
    run_txn(1'b0, 32'h40 + 32'(256 * 16), '0, D11 ^ D11 ^ D1);

    // Held request: read 0x80, keep req high for 20 cycles past the response.
    mem_req = 1'b1; mem_write = 1'b0; mem_addr = 32'h80; mem_data = '0;
    step(1);
    pulses = 0; busy_low = 0; held_data = '0;
    for (int i = 0; i < 25; i++) begin
      step(1);
      if (mem_resp_valid) begin
        pulses++;
        held_data = mem_resp_data;
      end
      if (!mem_busy) busy_low++;
    end
    check("held_one_pulse", 128'(pulses), 128'(1));
    check("held_data", held_data, D11);
    check("held_busy_stays", 128'(busy_low), 128'(0));
    check("held_state_hold", 128'(dbg_state), 128'(S_HOLD));
    mem_req = 1'b0;
    step(1);
    check("held_release_busy", 128'(mem_busy), 128'(0));

    // Early drop: req falls two cycles after acceptance; response still at k+5.
    mem_req = 1'b1; mem_write = 1'b0; mem_addr = 32'h40;
    step(1);
    step(2);
    mem_req = 1'b0;
    step(1);
    check("drop_k3_valid", 128'(mem_resp_valid), 128'(0));
    check("drop_k3_busy", 128'(mem_busy), 128'(1));
    step(1);
    check("drop_k4_valid", 128'(mem_resp_valid), 128'(0));
    step(1);
    check("drop_k5_valid", 128'(mem_resp_valid), 128'(1));
    check("drop_k5_data", mem_resp_data, D1);
    step(1);
    check("drop_k6_state", 128'(dbg_state), 128'(S_IDLE));

    // A write response leaves the last read data in place.
    run_txn(1'b1, 32'h200, D2, '0);
    check("wr_keeps_rd_data", mem_resp_data, D1);

    // Reset at k+3 of a write of 0xFF.. over 0x11.. at 0x80.
    mem_req = 1'b1; mem_write = 1'b1; mem_addr = 32'h80; mem_data = DFF;
    step(1);
    step(3);
    reset_n = 1'b0;
    mem_req = 1'b0;
    #1;
    check("mid_rst_state", 128'(dbg_state), 128'(S_IDLE));
    check("mid_rst_busy", 128'(mem_busy), 128'(0));
    check("mid_rst_data", mem_resp_data, 128'(0));
    #2;
    reset_n = 1'b1;
    // First edge after release accepts; the aborted write must neither pulse nor commit.
    run_txn(1'b0, 32'h80, '0, D11);

    // Latency 1, back-to-back.
    run_txn1(1'b1, 32'h40, D1, '0);
    run_txn1(1'b0, 32'h40, '0, D1);
    run_txn1(1'b1, 32'h50, D2, '0);
    run_txn1(1'b0, 32'h50, '0, D2);
    run_txn1(1'b0, 32'h40, '0, D1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
